ebus_arbiter: RTL and testbench

EBUS_ARBITER -- requirements
Module: ebus_arbiter

---
 rtl/ebus_arb_pkg.sv | 22 ++
 rtl/ebus_arbiter_rr_pick.sv | 27 ++
 rtl/ebus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ebus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebus_arb_pkg.sv
// Shared types and constants for the EBUS arbiter: state encoding, bus field
// widths and a multiple-driver detector.
package ebus_arb_pkg;

    localparam int CS_W   = 7;
    localparam int FUNC_W = 3;
    localparam int DRV_W  = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        DEMAND  = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_driver(input logic [DRV_W-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/ebus_arbiter_rr_pick.sv
// Combinational round-robin picker: searches req starting one slot after the
// last grant, wrapping at NREQ-1, and returns a one-hot winner.
module rr_pick #(
    parameter int NREQ  = 8,
    parameter int IDX_W = 3
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  win,
    output logic             valid
);

    always_comb begin : pick
        int idx;
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last) + off) % NREQ;
            if (!valid && req[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ebus_arbiter.sv
// EBUS arbiter: grants one requester at a time, drives its select/function
// codes onto the bus, runs the demand/acknowledge handshake with a timeout.
module ebus_arbiter
    import ebus_arb_pkg::*;
#(
    parameter int NREQ = 8,
    parameter int TMO  = 15
) (
    input  logic                   clk,
    input  logic                   crobar,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*CS_W-1:0]   reqCs,
    input  logic [NREQ*FUNC_W-1:0] reqFunc,
    output logic [NREQ-1:0]        grant,
    output logic [CS_W-1:0]        ebusCs,
    output logic [FUNC_W-1:0]      ebusFunc,
    output logic                   ebusDemand,
    input  logic                   ebusXfer,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        timeout,
    input  logic [DRV_W-1:0]       drvVec,
    output logic                   contention,
    input  logic                   clrErr,
    output logic                   busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Pointing at the last slot makes the first search after reset begin at slot 0.
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TMO - 1);

    logic [CS_W-1:0]   cs_slot   [NREQ];
    logic [FUNC_W-1:0] func_slot [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
            assign cs_slot[gi]   = reqCs[gi*CS_W +: CS_W];
            assign func_slot[gi] = reqFunc[gi*FUNC_W +: FUNC_W];
        end
    endgenerate

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [CS_W-1:0]   cs_q, cs_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic              demand_q, demand_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   timeout_q, timeout_d;
    logic              contention_q, contention_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  last_q, last_d;

    logic [NREQ-1:0]   win;
    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .win   (win),
        .valid (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cs_d      = cs_q;
        func_d    = func_q;
        demand_d  = demand_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        done_d    = '0;
        timeout_d = '0;

        case (state_q)
            IDLE: begin
                // Codes are latched with the grant so they hold from SETUP onward
                // regardless of what the requester does afterwards.
                if (win_valid) begin
                    grant_d = win;
                    last_d  = win_idx;
                    cs_d    = cs_slot[win_idx];
                    func_d  = func_slot[win_idx];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                demand_d = 1'b1;
                cnt_d    = '0;
                state_d  = DEMAND;
            end
            DEMAND: begin
                cnt_d = cnt_q + 1'b1;
                if (ebusXfer) begin
                    done_d   = grant_q;
                    demand_d = 1'b0;
                    state_d  = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = grant_q;
                    demand_d  = 1'b0;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                if (!ebusXfer) begin
                    grant_d = '0;
                    cs_d    = '0;
                    func_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (multi_driver(drvVec)) begin
            contention_d = 1'b1;
        end else if (clrErr) begin
            contention_d = 1'b0;
        end else begin
            contention_d = contention_q;
        end
    end

    always_ff @(posedge clk) begin
        if (crobar) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            cs_q         <= '0;
            func_q       <= '0;
            demand_q     <= 1'b0;
            done_q       <= '0;
            timeout_q    <= '0;
            contention_q <= 1'b0;
            cnt_q        <= '0;
            last_q       <= LAST_INIT;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cs_q         <= cs_d;
            func_q       <= func_d;
            demand_q     <= demand_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            contention_q <= contention_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
        end
    end

    assign grant      = grant_q;
    assign ebusCs     = cs_q;
    assign ebusFunc   = func_q;
    assign ebusDemand = demand_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign contention = contention_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ebus_arbiter.sv
// Directed bench for ebus_arbiter: stimulus pushes expected grant/done/timeout
// events into a queue, a negedge monitor pops and compares them as they occur.
module tb_ebus_arbiter;

    localparam int NREQ = 8;
    localparam int TMO  = 15;

    logic              clk = 1'b0;
    logic              crobar;
    logic [NREQ-1:0]   req;
    logic [NREQ*7-1:0] reqCs;
    logic [NREQ*3-1:0] reqFunc;
    logic [NREQ-1:0]   grant;
    logic [6:0]        ebusCs;
    logic [2:0]        ebusFunc;
    logic              ebusDemand;
    logic              ebusXfer;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   timeout;
    logic [31:0]       drvVec;
    logic              contention;
    logic              clrErr;
    logic              busy;

    ebus_arbiter #(
        .NREQ (NREQ),
        .TMO  (TMO)
    ) dut (
        .clk        (clk),
        .crobar     (crobar),
        .req        (req),
        .reqCs      (reqCs),
        .reqFunc    (reqFunc),
        .grant      (grant),
        .ebusCs     (ebusCs),
        .ebusFunc   (ebusFunc),
        .ebusDemand (ebusDemand),
        .ebusXfer   (ebusXfer),
        .done       (done),
        .timeout    (timeout),
        .drvVec     (drvVec),
        .contention (contention),
        .clrErr     (clrErr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum int {EV_GRANT, EV_DONE, EV_TMO} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] val;
    } ev_t;
    ev_t exp_q[$];

    logic [6:0] cs_tab [NREQ];
    logic [2:0] fn_tab [NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic push_ev(input ev_kind_e k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k, input logic [7:0] v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: got %s 0x%0h, want no event", k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val !== v) begin
                n_fail++;
                $display("FAIL scoreboard: got %s 0x%0h, want %s 0x%0h",
                         k.name(), v, e.kind.name(), e.val);
            end else begin
                $display("ok   scoreboard %s 0x%0h", k.name(), v);
            end
        end
    endtask

    // Monitor: decoupled from stimulus, fires on every output event.
    logic [NREQ-1:0] prev_grant = '0;
    always @(negedge clk) begin
        if (crobar === 1'b0) begin
            if (grant != '0 && prev_grant == '0) begin
                observe(EV_GRANT, grant);
                chk("grant_onehot", 32'($countones(grant)), 32'd1);
            end
            if (done != '0)    observe(EV_DONE, done);
            if (timeout != '0) observe(EV_TMO, timeout);
        end
        prev_grant = grant;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        crobar   = 1'b1;
        req      = '0;
        ebusXfer = 1'b0;
        drvVec   = '0;
        clrErr   = 1'b0;
        step();
        step();
        crobar = 1'b0;
    endtask

    task automatic wait_demand(input string name);
        int n = 0;
        while (!ebusDemand && n < 30) begin
            step();
            n++;
        end
        chk({name, "_demand_seen"}, 32'(ebusDemand), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 30) begin
            step();
            n++;
        end
        chk({name, "_idle_seen"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, want $finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] v;

        for (int i = 0; i < NREQ; i++) begin
            cs_tab[i] = 7'(i * 9 + 3);
            fn_tab[i] = 3'(7 - i);
        end
        cs_tab[0] = 7'o14;
        fn_tab[0] = 3'b010;
        for (int i = 0; i < NREQ; i++) begin
            reqCs[i*7 +: 7]   = cs_tab[i];
            reqFunc[i*3 +: 3] = fn_tab[i];
        end

        // Reset state
        apply_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_demand", 32'(ebusDemand), 0);
        chk("rst_cs", 32'(ebusCs), 0);
        chk("rst_contention", 32'(contention), 0);

        // Single transfer, slot 0, xfer at cycle 4
        push_ev(EV_GRANT, 8'h01);
        push_ev(EV_DONE, 8'h01);
        req = 8'h01;
        step();                                   // cycle 1
        chk("t1_c1_grant", 32'(grant), 32'h01);
        chk("t1_c1_busy", 32'(busy), 1);
        chk("t1_c1_demand", 32'(ebusDemand), 0);
        req = 8'h00;
        step();                                   // cycle 2
        chk("t1_c2_demand", 32'(ebusDemand), 1);
        chk("t1_c2_cs", 32'(ebusCs), 32'o14);
        chk("t1_c2_func", 32'(ebusFunc), 32'b010);
        step();                                   // cycle 3
        chk("t1_c3_demand", 32'(ebusDemand), 1);
        step();                                   // cycle 4
        chk("t1_c4_demand", 32'(ebusDemand), 1);
        ebusXfer = 1'b1;
        step();                                   // cycle 5
        chk("t1_c5_done", 32'(done), 32'h01);
        chk("t1_c5_demand", 32'(ebusDemand), 0);
        ebusXfer = 1'b0;
        step();                                   // cycle 6
        chk("t1_c6_busy", 32'(busy), 0);
        chk("t1_c6_grant", 32'(grant), 0);
        chk("t1_c6_cs", 32'(ebusCs), 0);

        // Round-robin rotation with all requesters held
        apply_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            v = 8'(1 << (i % 8));
            push_ev(EV_GRANT, v);
            push_ev(EV_DONE, v);
            wait_demand("rr");
            chk("rr_cs", 32'(ebusCs), 32'(cs_tab[i % 8]));
            chk("rr_func", 32'(ebusFunc), 32'(fn_tab[i % 8]));
            step();
            ebusXfer = 1'b1;
            step();
            ebusXfer = 1'b0;
        end
        req = 8'h00;
        wait_idle("rr");

        // Timeout on slot 2
        apply_reset();
        push_ev(EV_GRANT, 8'h04);
        push_ev(EV_TMO, 8'h04);
        req = 8'h04;
        step();
        req = 8'h00;
        step();
        n = 0;
        while (ebusDemand && n < 40) begin
            n++;
            step();
        end
        chk("tmo_demand_cycles", 32'(n), 32'd15);
        chk("tmo_pulse", 32'(timeout), 32'h04);
        chk("tmo_no_done", 32'(done), 0);
        step();
        chk("tmo_busy_drop", 32'(busy), 0);
        chk("tmo_pulse_end", 32'(timeout), 0);

        // Xfer on the timeout-count cycle: done wins; RELEASE holds while xfer high
        apply_reset();
        push_ev(EV_GRANT, 8'h01);
        push_ev(EV_DONE, 8'h01);
        req = 8'h01;
        step();
        req = 8'h00;
        step();                                   // cycle 2
        repeat (14) step();                       // cycle 16
        chk("race_c16_demand", 32'(ebusDemand), 1);
        chk("race_c16_timeout", 32'(timeout), 0);
        ebusXfer = 1'b1;
        step();                                   // cycle 17
        chk("race_done", 32'(done), 32'h01);
        chk("race_no_timeout", 32'(timeout), 0);
        chk("race_demand_low", 32'(ebusDemand), 0);
        step();                                   // cycle 18, xfer still high
        chk("race_release_hold", 32'(busy), 1);
        chk("race_release_grant", 32'(grant), 32'h01);
        ebusXfer = 1'b0;
        step();                                   // cycle 19
        chk("race_idle", 32'(busy), 0);
        chk("race_grant_clear", 32'(grant), 0);

        // Reset during DEMAND, then pointer restarts from slot 0
        apply_reset();
        push_ev(EV_GRANT, 8'h04);
        req = 8'h04;
        step();
        req = 8'h00;
        step();
        step();
        chk("rstmid_demand_before", 32'(ebusDemand), 1);
        crobar = 1'b1;
        step();
        chk("rstmid_demand", 32'(ebusDemand), 0);
        chk("rstmid_grant", 32'(grant), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_timeout", 32'(timeout), 0);
        chk("rstmid_busy", 32'(busy), 0);
        crobar = 1'b0;
        step();
        chk("rstmid_no_pulse", 32'(done | timeout), 0);
        push_ev(EV_GRANT, 8'h04);
        push_ev(EV_DONE, 8'h04);
        req = 8'h84;
        step();
        chk("rstmid_ptr_grant", 32'(grant), 32'h04);
        req = 8'h00;
        wait_demand("rstmid_a");
        ebusXfer = 1'b1;
        step();
        ebusXfer = 1'b0;
        wait_idle("rstmid_a");
        push_ev(EV_GRANT, 8'h80);
        push_ev(EV_DONE, 8'h80);
        req = 8'h80;
        step();
        chk("rstmid_grant80", 32'(grant), 32'h80);
        req = 8'h00;
        wait_demand("rstmid_b");
        ebusXfer = 1'b1;
        step();
        ebusXfer = 1'b0;
        wait_idle("rstmid_b");

        // Contention flag
        apply_reset();
        drvVec = 32'h0000_0003;
        step();
        chk("cont_set", 32'(contention), 1);
        drvVec = 32'h0;
        step();
        chk("cont_sticky", 32'(contention), 1);
        drvVec = 32'h11;
        clrErr = 1'b1;
        step();
        chk("cont_set_wins", 32'(contention), 1);
        drvVec = 32'h0;
        step();
        chk("cont_clear", 32'(contention), 0);
        clrErr = 1'b0;
        drvVec = 32'h8000_0000;
        step();
        chk("cont_single_driver", 32'(contention), 0);
        drvVec = 32'h8000_0001;
        step();
        chk("cont_wide_pair", 32'(contention), 1);
        drvVec = 32'h0;

        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
